register_file_2r1w: RTL and testbench

- Parametrised successor to the single-port register RAM: one synchronous write port, two independent synchronous read ports (A, B), configurable width and depth.
- Built-in clear sequencer fills every entry with INIT_VALUE after reset, or on request, and gates normal access until the fill completes.
- Serves as the CPU register bank and scratch store; the microsequencer reads two operands per cycle.

---
 rtl/register_file_2r1w.sv | 127 ++++++++++++
 tb/tb_register_file_2r1w.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// Two-read / one-write register file with a built-in clear sequencer that fills every entry with INIT_VALUE.
// Optional macro REGFILE_WRITE_BYPASS_EN enables write-first forwarding to the read ports.
module register_file_2r1w #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 8'hF5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    output logic                  ready,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] read_address_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    input  logic [ADDR_WIDTH-1:0] read_address_b,
    output logic [DATA_WIDTH-1:0] data_out_b
);

    localparam int                DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic {
        S_FILL  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  r_ready;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;

    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic [DATA_WIDTH-1:0] r_dout_a;
    logic [DATA_WIDTH-1:0] r_dout_b;

    // The single array write port is shared between the fill sequencer and the user write.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mem_we    = 1'b0;
        w_mem_addr  = write_address;
        w_mem_data  = data_in;
        w_capture   = 1'b0;
        case (r_state)
            S_FILL: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_count[ADDR_WIDTH-1:0];
                w_mem_data  = INIT_VALUE;
                w_count_nxt = r_count + 1'b1;
                if (r_count == LAST) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                w_capture = 1'b1;
                if (clear) begin
                    w_state_nxt = S_FILL;
                    w_count_nxt = '0;
                end else begin
                    w_mem_we = write_en;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FILL;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_ready <= (w_state_nxt == S_READY);
        end
    end

    // Array contents are deliberately not reset; the fill sequencer initialises them.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_comb begin
        w_rd_a = r_mem[read_address_a];
        w_rd_b = r_mem[read_address_b];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forwarding only matters in READY (w_capture); a clear edge drops the write, so no forward.
        if (write_en && !clear && (write_address == read_address_a)) begin
            w_rd_a = data_in;
        end
        if (write_en && !clear && (write_address == read_address_b)) begin
            w_rd_b = data_in;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dout_a <= '0;
            r_dout_b <= '0;
        end else if (w_capture) begin
            r_dout_a <= w_rd_a;
            r_dout_b <= w_rd_b;
        end
    end

    assign ready      = r_ready;
    assign data_out_a = r_dout_a;
    assign data_out_b = r_dout_b;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench for register_file_2r1w (ADDR_WIDTH=4): reads push expectations, a monitor pops and compares.
module tb_register_file_2r1w;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       ready;
    logic       write_en = 1'b0;
    logic [3:0] write_address = '0;
    logic [7:0] data_in = '0;
    logic [3:0] read_address_a = '0;
    logic [7:0] data_out_a;
    logic [3:0] read_address_b = '0;
    logic [7:0] data_out_b;

    int n_vec = 0;
    int n_err = 0;
    logic        tb_rd = 1'b0;
    logic        mon_vld = 1'b0;
    logic [15:0] exp_q [$];

    register_file_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .INIT_VALUE(8'hF5)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .ready(ready),
        .write_en(write_en), .write_address(write_address), .data_in(data_in),
        .read_address_a(read_address_a), .data_out_a(data_out_a),
        .read_address_b(read_address_b), .data_out_b(data_out_b)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Monitor: a read issued before edge k is checked on the falling edge after k.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) mon_vld <= 1'b0;
        else          mon_vld <= tb_rd;
    end

    always @(negedge clock) begin
        logic [15:0] e;
        if (mon_vld) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow: got a=%h b=%h, no expectation queued", data_out_a, data_out_b);
            end else begin
                e = exp_q.pop_front();
                if (data_out_a !== e[15:8] || data_out_b !== e[7:0]) begin
                    n_err++;
                    $display("FAIL read: got a=%h b=%h, expected a=%h b=%h", data_out_a, data_out_b, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic clr, input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic chk, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [7:0] ea, input logic [7:0] eb);
        @(negedge clock);
        clear = clr; write_en = we; write_address = wa; data_in = wd;
        read_address_a = ra; read_address_b = rb; tb_rd = chk;
        if (chk) exp_q.push_back({ea, eb});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
    endtask

    task automatic wait_fill(input string name, input logic chk_zero);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clock); #1;
            check(name, {7'd0, ready}, (i == 16) ? 8'd1 : 8'd0);
            if (chk_zero) begin
                check({name, "_dout_a"}, data_out_a, 8'h00);
                check({name, "_dout_b"}, data_out_b, 8'h00);
            end
        end
    endtask

    logic [7:0] coll_exp;

    initial begin
        // Reset fill, with a write held during FILL that must be ignored.
        write_en = 1'b1; write_address = 4'd2; data_in = 8'h55;
        repeat (3) @(negedge clock);
        check("reset_ready", {7'd0, ready}, 8'd0);
        check("reset_dout_a", data_out_a, 8'h00);
        check("reset_dout_b", data_out_b, 8'h00);
        reset_n = 1'b1;
        wait_fill("fill_ready", 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 4'(15 - i), 8'hF5, 8'hF5);
        end

        // Basic write then read.
        step(1'b0, 1'b1, 4'd5, 8'h3C, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 4'd5, 8'h3C, 8'h3C);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 4'd5, 8'hF5, 8'h3C);

        // Same-address collision on both ports.
`ifdef REGFILE_WRITE_BYPASS_EN
        coll_exp = 8'hA7;
`else
        coll_exp = 8'h11;
`endif
        step(1'b0, 1'b1, 4'd9, 8'h11, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 4'd9, 8'hA7, 1'b1, 4'd9, 4'd9, coll_exp, coll_exp);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 4'd2, 8'hA7, 8'hF5);

        // Clear mid-operation; the clear edge still captures its read, the write is dropped.
        step(1'b0, 1'b1, 4'd0, 8'h01, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 4'd15, 8'h02, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
        step(1'b1, 1'b1, 4'd3, 8'h77, 1'b1, 4'd0, 4'd15, 8'h01, 8'h02);
        @(posedge clock); #1;
        check("clear_ready_drop", {7'd0, ready}, 8'd0);
        idle();
        wait_fill("clear_ready", 1'b0);
        check("clear_hold_a", data_out_a, 8'h01);
        check("clear_hold_b", data_out_b, 8'h02);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 4'd3, 8'hF5, 8'hF5);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 4'd9, 8'hF5, 8'hF5);
        idle();

        // Reset in the middle of a fill.
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (7) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset_ready", {7'd0, ready}, 8'd0);
        check("midreset_dout_a", data_out_a, 8'h00);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_fill("refill_ready", 1'b1);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 4'd12, 8'hF5, 8'hF5);
        idle();

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
